// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the 1101 serial pattern detector.
// Build option: define SEQ_OVERLAP_EN to let the trailing 1 of a match start the next pattern.
package seq_det_pkg;

    localparam int unsigned STATE_W     = 3;
    localparam int unsigned RUN_W       = 4;
    localparam int unsigned CNT_W_DEF   = 8;
    localparam int unsigned RUN_MAX_DEF = 4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 3'd0,
        S_1    = 3'd1,
        S_11   = 3'd2,
        S_110  = 3'd3
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at MAX instead of wrapping.
module sat_counter #(
    parameter int unsigned W   = 8,
    parameter int unsigned MAX = (1 << W) - 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // NOTE: cnt_d gets its hold value first so every path assigns it and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < MAX_V)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mealy_out_seq_detector.sv
// Detects 1101 (MSB first) on a valid-qualified bit stream, counts matches and flags long runs of 1s.
// Build option: SEQ_OVERLAP_EN selects overlapping detection (next state S_1 after a match).
module mealy_out_seq_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned RUN_MAX = RUN_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               data_in,
    input  logic               valid_in,
    input  logic               clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               run_alarm,
    output logic [STATE_W-1:0] state_dbg
);

`ifdef SEQ_OVERLAP_EN
    localparam state_t AFTER_MATCH = S_1;
`else
    localparam state_t AFTER_MATCH = S_IDLE;
`endif

    localparam logic [RUN_W-1:0] RUN_MAX_V = RUN_W'(RUN_MAX);

    state_t           state_q;
    logic             match_q;
    logic             run_alarm_q;
    logic             run_alarm_d;
    logic [RUN_W-1:0] run_len;
    logic             bit_one;
    logic             bit_zero;
    logic             match_hit;

    assign bit_one   = valid_in & data_in;
    assign bit_zero  = valid_in & ~data_in;
    assign match_hit = bit_one & (state_q == S_110);

    sat_counter #(
        .W   (CNT_W),
        .MAX ((1 << CNT_W) - 1)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr),
        .inc_i (match_hit),
        .cnt_o (match_cnt)
    );

    sat_counter #(
        .W   (RUN_W),
        .MAX (RUN_MAX)
    ) u_run_len (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr | bit_zero),
        .inc_i (bit_one),
        .cnt_o (run_len)
    );

    // Alarm tracks the run length the counter is about to take, so both move on the same edge.
    always_comb begin
        run_alarm_d = 1'b0;
        if (clr || bit_zero) begin
            run_alarm_d = 1'b0;
        end else if (bit_one) begin
            run_alarm_d = (run_len >= (RUN_MAX_V - RUN_W'(1)));
        end else begin
            run_alarm_d = (run_len == RUN_MAX_V);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            match_q     <= 1'b0;
            run_alarm_q <= 1'b0;
        end else if (clr) begin
            state_q     <= S_IDLE;
            match_q     <= 1'b0;
            run_alarm_q <= 1'b0;
        end else begin
            match_q     <= match_hit;
            run_alarm_q <= run_alarm_d;
            case (state_q)
                S_IDLE: if (valid_in) state_q <= data_in ? S_1  : S_IDLE;
                S_1:    if (valid_in) state_q <= data_in ? S_11 : S_IDLE;
                S_11:   if (valid_in) state_q <= data_in ? S_11 : S_110;
                S_110:  if (valid_in) state_q <= data_in ? AFTER_MATCH : S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign match     = match_q;
    assign run_alarm = run_alarm_q;
    assign state_dbg = state_q;

endmodule
